// File: rtl/oled_power_seq_if.sv
// Signal bundle between the OLED power sequencer and its environment:
// start request, delay-generator and SPI handshakes, and the panel control pins.
interface oled_power_seq_if;
    logic       start;
    logic       delayEn;
    logic       delayDone;
    logic       spiSend;
    logic [7:0] spiData;
    logic       spiDone;
    logic       oledDc;
    logic       oledResN;
    logic       oledVddN;
    logic       oledVbatN;
    logic       initDone;

    modport master (
        input  start, delayDone, spiDone,
        output delayEn, spiSend, spiData, oledDc, oledResN, oledVddN, oledVbatN, initDone
    );

    modport slave (
        output start, delayDone, spiDone,
        input  delayEn, spiSend, spiData, oledDc, oledResN, oledVddN, oledVbatN, initDone
    );
endinterface

// File: rtl/oled_power_seq.sv
// OLED panel power-up sequencer: supplies, panel reset and the fixed command
// string, paced by an external 2 ms delay generator and an SPI byte transmitter.
module oled_power_seq #(
    parameter int RES_UNITS  = 1,
    parameter int VBAT_UNITS = 50
) (
    input  logic              clock,
    input  logic              reset,
    oled_power_seq_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_VDD_ON,
        S_SEND_CMD,
        S_WAIT_SPI,
        S_RES_LOW,
        S_RES_HIGH,
        S_VBAT_ON,
        S_DONE
    } state_t;

    localparam logic [15:0] RES_LAST   = 16'(RES_UNITS - 1);
    localparam logic [15:0] VBAT_LAST  = 16'(VBAT_UNITS - 1);
    localparam logic [3:0]  BYTE_FIRST = 4'd0;
    localparam logic [3:0]  BYTE_F1    = 4'd4;
    localparam logic [3:0]  BYTE_LAST  = 4'd11;

    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_byte = 8'hAE;
            4'd1:    cmd_byte = 8'h8D;
            4'd2:    cmd_byte = 8'h14;
            4'd3:    cmd_byte = 8'hD9;
            4'd4:    cmd_byte = 8'hF1;
            4'd5:    cmd_byte = 8'h81;
            4'd6:    cmd_byte = 8'h0F;
            4'd7:    cmd_byte = 8'hA1;
            4'd8:    cmd_byte = 8'hC8;
            4'd9:    cmd_byte = 8'hDA;
            4'd10:   cmd_byte = 8'h20;
            4'd11:   cmd_byte = 8'hAF;
            default: cmd_byte = 8'h00;
        endcase
    endfunction

    function automatic logic is_wait(input state_t s);
        is_wait = (s == S_VDD_ON) || (s == S_RES_LOW) || (s == S_RES_HIGH) || (s == S_VBAT_ON);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] unit_q, unit_d;
    logic [3:0]  byte_q, byte_d;

    logic        delay_en_q, delay_en_d;
    logic        spi_send_q, spi_send_d;
    logic [7:0]  spi_data_q, spi_data_d;
    logic        res_n_q, res_n_d;
    logic        vdd_n_q, vdd_n_d;
    logic        vbat_n_q, vbat_n_d;
    logic        init_done_q, init_done_d;

    logic        unit_tick;
    logic        unit_last;

    // A delayDone only counts while the registered request is high, so
    // pulses arriving in the gap cycle between waits are dropped.
    assign unit_tick = delay_en_q && bus.delayDone;
    assign unit_last = (state_q == S_VBAT_ON) ? (unit_q == VBAT_LAST) : (unit_q == RES_LAST);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unit_d  = unit_q;
        byte_d  = byte_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_VDD_ON;
            end
            S_VDD_ON, S_RES_LOW, S_RES_HIGH, S_VBAT_ON: begin
                if (unit_tick) begin
                    if (unit_last) begin
                        unit_d  = '0;
                        state_d = (state_q == S_RES_LOW) ? S_RES_HIGH : S_SEND_CMD;
                    end else begin
                        unit_d = unit_q + 16'd1;
                    end
                end
            end
            S_SEND_CMD: begin
                state_d = S_WAIT_SPI;
            end
            S_WAIT_SPI: begin
                if (bus.spiDone) begin
                    byte_d = byte_q + 4'd1;
                    if (byte_q == BYTE_FIRST)     state_d = S_RES_LOW;
                    else if (byte_q == BYTE_F1)   state_d = S_VBAT_ON;
                    else if (byte_q == BYTE_LAST) state_d = S_DONE;
                    else                          state_d = S_SEND_CMD;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register in step
        // with it; entering a wait leaves delayEn low for its first cycle.
        delay_en_d  = is_wait(state_d) && (state_d == state_q);
        spi_send_d  = (state_d == S_SEND_CMD);
        spi_data_d  = (state_d == S_SEND_CMD) ? cmd_byte(byte_d) : spi_data_q;
        res_n_d     = (state_d != S_RES_LOW);
        vdd_n_d     = vdd_n_q  && (state_d != S_VDD_ON);
        vbat_n_d    = vbat_n_q && (state_d != S_VBAT_ON);
        init_done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            unit_q      <= '0;
            byte_q      <= '0;
            delay_en_q  <= 1'b0;
            spi_send_q  <= 1'b0;
            spi_data_q  <= 8'h00;
            res_n_q     <= 1'b1;
            vdd_n_q     <= 1'b1;
            vbat_n_q    <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            byte_q      <= byte_d;
            delay_en_q  <= delay_en_d;
            spi_send_q  <= spi_send_d;
            spi_data_q  <= spi_data_d;
            res_n_q     <= res_n_d;
            vdd_n_q     <= vdd_n_d;
            vbat_n_q    <= vbat_n_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.delayEn   = delay_en_q;
    assign bus.spiSend   = spi_send_q;
    assign bus.spiData   = spi_data_q;
    assign bus.oledDc    = 1'b0;
    assign bus.oledResN  = res_n_q;
    assign bus.oledVddN  = vdd_n_q;
    assign bus.oledVbatN = vbat_n_q;
    assign bus.initDone  = init_done_q;

endmodule

// File: tb/tb_oled_power_seq.sv
// Directed bench for oled_power_seq with a 20-cycle delay generator model and
// an SPI model answering 10 cycles after each spiSend.
module tb_oled_power_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic force_dd = 1'b0, force_sd = 1'b0;
    logic model_dd = 1'b0, model_sd = 1'b0;
    logic spi_hold = 1'b0;

    int total = 0;
    int bad   = 0;

    int dcnt = 0, scnt = 0;
    int dd_total = 0, vbat_total = 0, byte_total = 0;
    int pulse_err = 0, dc_err = 0;
    logic prev_send = 1'b0;
    logic [7:0] byte_log [256];
    logic [7:0] exp_bytes [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                                   8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

    oled_power_seq_if bus();

    assign bus.start     = start;
    assign bus.delayDone = model_dd | force_dd;
    assign bus.spiDone   = model_sd | force_sd;

    oled_power_seq #(.RES_UNITS(1), .VBAT_UNITS(50)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Delay generator: one pulse per 20 cycles of delayEn high.
    always @(negedge clock) begin
        if (reset || !bus.delayEn) begin
            dcnt     = 0;
            model_dd = 1'b0;
        end else begin
            dcnt = dcnt + 1;
            if (dcnt == 20) begin
                model_dd = 1'b1;
                dcnt     = 0;
                dd_total = dd_total + 1;
                if (!bus.oledVbatN) vbat_total = vbat_total + 1;
            end else begin
                model_dd = 1'b0;
            end
        end
    end

    // SPI transmitter: spiDone 10 cycles after spiSend unless held off.
    always @(negedge clock) begin
        model_sd = 1'b0;
        if (reset) begin
            scnt = 0;
        end else if (scnt != 0) begin
            scnt = scnt - 1;
            if (scnt == 0) model_sd = 1'b1;
        end else if (bus.spiSend && !spi_hold) begin
            scnt = 10;
        end
    end

    always @(negedge clock) begin
        if (bus.spiSend === 1'b1) begin
            if (byte_total < 256) byte_log[byte_total] = bus.spiData;
            byte_total = byte_total + 1;
            if (prev_send) pulse_err = pulse_err + 1;
        end
        prev_send = bus.spiSend;
        if (bus.oledDc !== 1'b0) dc_err = dc_err + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_send(input int limit);
        for (int i = 0; i < limit && bus.spiSend !== 1'b1; i++) step();
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && bus.initDone !== 1'b1; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        total++; if (bus.delayEn   !== 1'b0)  begin bad++; $display("FAIL rst_delayEn got=%b want=0", bus.delayEn); end
        total++; if (bus.spiSend   !== 1'b0)  begin bad++; $display("FAIL rst_spiSend got=%b want=0", bus.spiSend); end
        total++; if (bus.spiData   !== 8'h00) begin bad++; $display("FAIL rst_spiData got=%h want=00", bus.spiData); end
        total++; if (bus.oledDc    !== 1'b0)  begin bad++; $display("FAIL rst_oledDc got=%b want=0", bus.oledDc); end
        total++; if (bus.oledResN  !== 1'b1)  begin bad++; $display("FAIL rst_oledResN got=%b want=1", bus.oledResN); end
        total++; if (bus.oledVddN  !== 1'b1)  begin bad++; $display("FAIL rst_oledVddN got=%b want=1", bus.oledVddN); end
        total++; if (bus.oledVbatN !== 1'b1)  begin bad++; $display("FAIL rst_oledVbatN got=%b want=1", bus.oledVbatN); end
        total++; if (bus.initDone  !== 1'b0)  begin bad++; $display("FAIL rst_initDone got=%b want=0", bus.initDone); end
        pulse_start();
        step();
        total++; if (bus.oledVddN  !== 1'b1)  begin bad++; $display("FAIL rst_start_vdd got=%b want=1", bus.oledVddN); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_full_sequence();
        int bb, bd, bv;
        bb = byte_total; bd = dd_total; bv = vbat_total;
        pulse_start();
        step();
        total++; if (bus.oledVddN !== 1'b0) begin bad++; $display("FAIL full_vdd_on got=%b want=0", bus.oledVddN); end
        total++; if (bus.delayEn  !== 1'b1) begin bad++; $display("FAIL full_delayEn got=%b want=1", bus.delayEn); end
        total++; if (bus.oledVbatN !== 1'b1) begin bad++; $display("FAIL full_vbat_early got=%b want=1", bus.oledVbatN); end
        wait_send(100);
        total++; if (bus.spiSend !== 1'b1) begin bad++; $display("FAIL full_first_send got=%b want=1", bus.spiSend); end
        total++; if (bus.spiData !== 8'hAE) begin bad++; $display("FAIL full_first_byte got=%h want=ae", bus.spiData); end
        total++; if (dd_total - bd !== 1) begin bad++; $display("FAIL full_first_units got=%0d want=1", dd_total - bd); end
        wait_done(4000);
        total++; if (bus.initDone !== 1'b1) begin bad++; $display("FAIL full_initDone got=%b want=1", bus.initDone); end
        total++; if (byte_total - bb !== 12) begin bad++; $display("FAIL full_byte_count got=%0d want=12", byte_total - bb); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (byte_log[bb + i] !== exp_bytes[i]) begin
                bad++; $display("FAIL full_byte%0d got=%h want=%h", i, byte_log[bb + i], exp_bytes[i]);
            end
        end
        total++; if (vbat_total - bv !== 50) begin bad++; $display("FAIL full_vbat_units got=%0d want=50", vbat_total - bv); end
        step();
        total++; if (bus.delayEn   !== 1'b0) begin bad++; $display("FAIL full_done_delayEn got=%b want=0", bus.delayEn); end
        total++; if (bus.spiSend   !== 1'b0) begin bad++; $display("FAIL full_done_spiSend got=%b want=0", bus.spiSend); end
        total++; if (bus.oledVddN  !== 1'b0) begin bad++; $display("FAIL full_done_vdd got=%b want=0", bus.oledVddN); end
        total++; if (bus.oledVbatN !== 1'b0) begin bad++; $display("FAIL full_done_vbat got=%b want=0", bus.oledVbatN); end
        total++; if (bus.oledResN  !== 1'b1) begin bad++; $display("FAIL full_done_resn got=%b want=1", bus.oledResN); end
    endtask

    task automatic test_spurious();
        int bb, bv;
        do_reset();
        bb = byte_total; bv = vbat_total;
        pulse_start();
        force_dd = 1'b1; force_sd = 1'b1;
        step();
        force_dd = 1'b0; force_sd = 1'b0;
        total++; if (bus.delayEn !== 1'b1) begin bad++; $display("FAIL spur_dd_delayEn got=%b want=1", bus.delayEn); end
        total++; if (bus.spiSend !== 1'b0) begin bad++; $display("FAIL spur_dd_spiSend got=%b want=0", bus.spiSend); end
        for (int i = 0; i < 100 && bus.oledResN !== 1'b0; i++) step();
        total++; if (bus.oledResN !== 1'b0) begin bad++; $display("FAIL spur_res_low got=%b want=0", bus.oledResN); end
        force_sd = 1'b1;
        step();
        force_sd = 1'b0;
        total++; if (bus.spiSend  !== 1'b0) begin bad++; $display("FAIL spur_sd_spiSend got=%b want=0", bus.spiSend); end
        total++; if (bus.oledResN !== 1'b0) begin bad++; $display("FAIL spur_sd_resn got=%b want=0", bus.oledResN); end
        wait_send(200);
        total++; if (bus.spiData !== 8'h8D) begin bad++; $display("FAIL spur_second_byte got=%h want=8d", bus.spiData); end
        step();
        force_dd = 1'b1;
        step();
        force_dd = 1'b0;
        total++; if (bus.spiSend !== 1'b0 || bus.spiData !== 8'h8D) begin
            bad++; $display("FAIL spur_wait_spi got=%b/%h want=0/8d", bus.spiSend, bus.spiData);
        end
        wait_done(4000);
        total++; if (bus.initDone !== 1'b1) begin bad++; $display("FAIL spur_initDone got=%b want=1", bus.initDone); end
        total++; if (byte_total - bb !== 12) begin bad++; $display("FAIL spur_byte_count got=%0d want=12", byte_total - bb); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (byte_log[bb + i] !== exp_bytes[i]) begin
                bad++; $display("FAIL spur_byte%0d got=%h want=%h", i, byte_log[bb + i], exp_bytes[i]);
            end
        end
        total++; if (vbat_total - bv !== 50) begin bad++; $display("FAIL spur_vbat_units got=%0d want=50", vbat_total - bv); end
    endtask

    task automatic test_start_ignored();
        int bb, b2;
        do_reset();
        bb = byte_total;
        pulse_start();
        wait_send(100);
        step();
        pulse_start();
        wait_done(4000);
        total++; if (bus.initDone !== 1'b1) begin bad++; $display("FAIL ign_initDone got=%b want=1", bus.initDone); end
        total++; if (byte_total - bb !== 12) begin bad++; $display("FAIL ign_byte_count got=%0d want=12", byte_total - bb); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (byte_log[bb + i] !== exp_bytes[i]) begin
                bad++; $display("FAIL ign_byte%0d got=%h want=%h", i, byte_log[bb + i], exp_bytes[i]);
            end
        end
        b2 = byte_total;
        pulse_start();
        repeat (40) step();
        total++; if (bus.initDone !== 1'b1) begin bad++; $display("FAIL ign_done_initDone got=%b want=1", bus.initDone); end
        total++; if (byte_total !== b2) begin bad++; $display("FAIL ign_done_bytes got=%0d want=%0d", byte_total, b2); end
        total++; if (bus.delayEn !== 1'b0) begin bad++; $display("FAIL ign_done_delayEn got=%b want=0", bus.delayEn); end
        total++; if (bus.oledVddN !== 1'b0) begin bad++; $display("FAIL ign_done_vdd got=%b want=0", bus.oledVddN); end
    endtask

    task automatic test_reset_mid_vbat();
        int bb, bv;
        do_reset();
        bv = vbat_total;
        pulse_start();
        for (int i = 0; i < 3000 && vbat_total - bv < 20; i++) step();
        total++; if (vbat_total - bv !== 20) begin bad++; $display("FAIL mid_units got=%0d want=20", vbat_total - bv); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (bus.oledVbatN !== 1'b1) begin bad++; $display("FAIL mid_vbat_off got=%b want=1", bus.oledVbatN); end
        total++; if (bus.oledVddN  !== 1'b1) begin bad++; $display("FAIL mid_vdd_off got=%b want=1", bus.oledVddN); end
        total++; if (bus.delayEn   !== 1'b0) begin bad++; $display("FAIL mid_delayEn got=%b want=0", bus.delayEn); end
        total++; if (bus.spiData   !== 8'h00) begin bad++; $display("FAIL mid_spiData got=%h want=00", bus.spiData); end
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        total++; if (bus.oledVddN !== 1'b1) begin bad++; $display("FAIL mid_idle_vdd got=%b want=1", bus.oledVddN); end
        bb = byte_total; bv = vbat_total;
        pulse_start();
        wait_send(100);
        total++; if (bus.spiData !== 8'hAE) begin bad++; $display("FAIL mid_first_byte got=%h want=ae", bus.spiData); end
        wait_done(4000);
        total++; if (bus.initDone !== 1'b1) begin bad++; $display("FAIL mid_initDone got=%b want=1", bus.initDone); end
        total++; if (byte_total - bb !== 12) begin bad++; $display("FAIL mid_byte_count got=%0d want=12", byte_total - bb); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (byte_log[bb + i] !== exp_bytes[i]) begin
                bad++; $display("FAIL mid_byte%0d got=%h want=%h", i, byte_log[bb + i], exp_bytes[i]);
            end
        end
        total++; if (vbat_total - bv !== 50) begin bad++; $display("FAIL mid_vbat_units got=%0d want=50", vbat_total - bv); end
    endtask

    task automatic test_spi_holdoff();
        int bb, errs;
        do_reset();
        spi_hold = 1'b1;
        bb = byte_total;
        pulse_start();
        wait_send(100);
        total++; if (bus.spiData !== 8'hAE) begin bad++; $display("FAIL hold_first_byte got=%h want=ae", bus.spiData); end
        errs = 0;
        repeat (1000) begin
            step();
            if (bus.spiData !== 8'hAE || bus.spiSend !== 1'b0 || bus.oledResN !== 1'b1 || bus.delayEn !== 1'b0)
                errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL hold_stable got=%0d bad cycles want=0", errs); end
        force_sd = 1'b1;
        step();
        force_sd = 1'b0;
        spi_hold = 1'b0;
        for (int i = 0; i < 10 && bus.oledResN !== 1'b0; i++) step();
        total++; if (bus.oledResN !== 1'b0) begin bad++; $display("FAIL hold_advance got=%b want=0", bus.oledResN); end
        wait_done(4000);
        total++; if (bus.initDone !== 1'b1) begin bad++; $display("FAIL hold_initDone got=%b want=1", bus.initDone); end
        total++; if (byte_total - bb !== 12) begin bad++; $display("FAIL hold_byte_count got=%0d want=12", byte_total - bb); end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (byte_log[bb + i] !== exp_bytes[i]) begin
                bad++; $display("FAIL hold_byte%0d got=%h want=%h", i, byte_log[bb + i], exp_bytes[i]);
            end
        end
    endtask

    task automatic test_monitors();
        total++; if (pulse_err !== 0) begin bad++; $display("FAIL mon_spiSend_width got=%0d long pulses want=0", pulse_err); end
        total++; if (dc_err !== 0) begin bad++; $display("FAIL mon_oledDc got=%0d nonzero cycles want=0", dc_err); end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_spurious();
        test_start_ignored();
        test_reset_mid_vbat();
        test_spi_holdoff();
        test_monitors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
